// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the initiator FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata,
    StResp,
    StHung
  } axi_state_e;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Cycles-in-state counter; flags expiry once an active state has lasted TIMEOUT_CYCLES cycles.
module axi_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed cycles in the current state, so it is 0 in the state's first cycle
  assign expired_o = active_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a host command/response port.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned AXI_ADDR_WIDTH = 18,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [STROBE_WIDTH-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [1:0]                rsp_resp,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
`ifdef AXI_MASTER_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic                      m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  input  logic                      m_axi_awready,
  output logic                      m_axi_wvalid,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [STROBE_WIDTH-1:0]   m_axi_wstrb,
  input  logic                      m_axi_wready,
  input  logic                      m_axi_bvalid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_bready,
  output logic                      m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_arready,
  input  logic                      m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  output logic                      m_axi_rready
);

  axi_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic aw_hs, w_hs;

  // Valids are pure functions of registered state, never of the ready inputs
  assign m_axi_awvalid = (state_q == StWrite) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == StWrite) && !w_done_q;
  assign m_axi_bready  = (state_q == StWresp);
  assign m_axi_arvalid = (state_q == StRaddr);
  assign m_axi_rready  = (state_q == StRdata);

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign rsp_valid = (state_q == StResp);
  assign rsp_write = rsp_write_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic timed_out_q, timed_out_d;
  logic timeout_err_q, timeout_err_d;
  logic wd_active, wd_expired;

  assign wd_active   = (state_q == StWrite) || (state_q == StWresp) ||
                       (state_q == StRaddr) || (state_q == StRdata);
  assign timeout_err = timeout_err_q;

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .active_i (wd_active),
    .clear_i  (state_d != state_q),
    .expired_o(wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef AXI_MASTER_TIMEOUT_EN
    timed_out_d   = timed_out_q;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrite : StRaddr;
        end
      end
      StWrite: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWresp;
      end
      StWresp: begin
        if (m_axi_bvalid) begin
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = StResp;
        end
      end
      StRaddr: begin
        if (m_axi_arready) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi_rvalid) begin
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
          rsp_write_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
`ifdef AXI_MASTER_TIMEOUT_EN
          state_d = timed_out_q ? StHung : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      StHung: state_d = StHung;
      default: state_d = StIdle;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Expiry overrides any handshake landing in the same cycle
    if (wd_expired) begin
      state_d       = StResp;
      rsp_resp_d    = RESP_DECERR;
      rsp_rdata_d   = '0;
      rsp_write_d   = (state_q == StWrite) || (state_q == StWresp);
      timed_out_d   = 1'b1;
      timeout_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= RESP_OKAY;
      rsp_rdata_q <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timed_out_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      timed_out_q   <= timed_out_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small AXI-Lite slave model with programmable stalls.
module tb_axi_lite_master;

  localparam int unsigned TbTimeout = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
`ifdef AXI_MASTER_TIMEOUT_EN
  logic        timeout_err;
`endif
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [17:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .TIMEOUT_CYCLES(TbTimeout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_resp     (rsp_resp),
    .rsp_rdata    (rsp_rdata),
`ifdef AXI_MASTER_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .m_axi_awvalid(awvalid),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awready(awready),
    .m_axi_wvalid (wvalid),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wready (wready),
    .m_axi_bvalid (bvalid),
    .m_axi_bresp  (bresp),
    .m_axi_bready (bready),
    .m_axi_arvalid(arvalid),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arready(arready),
    .m_axi_rvalid (rvalid),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rready (rready)
  );

  // ---------------- slave model: valid region is byte addresses 18'h10000..18'h1FFFF
  logic [31:0] mem [0:255];
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic ar_en = 1'b1;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [17:0] aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  function automatic logic addr_ok(input logic [17:0] a);
    return a[17:16] == 2'b01;
  endfunction

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign wready  = wvalid && !w_got && (w_cnt >= w_dly);
  assign arready = arvalid && ar_en && !ar_got && (ar_cnt >= ar_dly);

  always @(posedge clk) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
    end else begin
      if (awvalid && !awready && !aw_got) aw_cnt <= aw_cnt + 1;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_addr_q <= awaddr; aw_cnt <= 0; end
      if (wvalid && !wready && !w_got) w_cnt <= w_cnt + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_cnt <= 0;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        if (b_cnt >= b_dly) begin
          bvalid <= 1'b1;
          b_cnt  <= 0;
          bresp  <= addr_ok(aw_got ? aw_addr_q : awaddr) ? 2'b00 : 2'b10;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        if (addr_ok(aw_addr_q)) begin
          for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) mem[aw_addr_q[9:2]][8*i +: 8] <= w_data_q[8*i +: 8];
          end
        end
      end
      if (arvalid && !arready && !ar_got) ar_cnt <= ar_cnt + 1;
      if (arvalid && arready) begin ar_got <= 1'b1; ar_addr_q <= araddr; ar_cnt <= 0; end
      if ((ar_got || (arvalid && arready)) && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rvalid <= 1'b1;
          r_cnt  <= 0;
          if (addr_ok(ar_got ? ar_addr_q : araddr)) begin
            rdata <= mem[ar_got ? ar_addr_q[9:2] : araddr[9:2]];
            rresp <= 2'b00;
          end else begin
            rdata <= '0;
            rresp <= 2'b10;
          end
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (rvalid && rready) begin rvalid <= 1'b0; ar_got <= 1'b0; end
    end
  end

  // ---------------- protocol monitor
  int aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, b_hs_n = 0, aw_hs_n = 0, viol = 0;
  logic aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
  logic [17:0] aw_prev, ar_prev;
  logic [31:0] w_prev;

  always @(posedge clk) begin
    if (awvalid) aw_vcyc <= aw_vcyc + 1;
    if (wvalid)  w_vcyc  <= w_vcyc + 1;
    if (arvalid) ar_vcyc <= ar_vcyc + 1;
    if (bvalid && bready)   b_hs_n  <= b_hs_n + 1;
    if (awvalid && awready) aw_hs_n <= aw_hs_n + 1;
    if (!reset) begin
      if ((aw_hold && (!awvalid || awaddr != aw_prev)) ||
          (w_hold && (!wvalid || wdata != w_prev)) ||
          (ar_hold && (!arvalid || araddr != ar_prev))) viol <= viol + 1;
    end
    aw_hold <= awvalid && !awready && !reset;
    w_hold  <= wvalid && !wready && !reset;
    ar_hold <= arvalid && !arready && !reset;
    aw_prev <= awaddr; w_prev <= wdata; ar_prev <= araddr;
  end

  // ---------------- helpers
  logic        r_write;
  logic [1:0]  r_resp;
  logic [31:0] r_rdata;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [17:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cmd_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) chk("rsp_wait_timeout", 32'(lat), 32'd0);
    r_write = rsp_write; r_resp = rsp_resp; r_rdata = rsp_rdata;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // ---------------- directed sequence
  initial begin
    int aw0, w0, b0, ar0, n;
    logic stable;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: zero-wait write
    set_dly(0, 0, 0, 0, 0);
    aw0 = aw_hs_n; b0 = b_hs_n;
    issue(1'b1, 18'h10000, 32'h0000_1234, 4'hF);
    wait_rsp();
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_rsp_write", 32'(r_write), 32'd1);
    chk("wr_rsp_resp", 32'(r_resp), 32'd0);
    chk("wr_rsp_rdata", r_rdata, 32'd0);
    chk("wr_aw_hs", 32'(aw_hs_n - aw0), 32'd1);
    chk("wr_b_hs", 32'(b_hs_n - b0), 32'd1);
    consume();

    // 2: zero-wait read back
    issue(1'b0, 18'h10000, 32'h0, 4'h0);
    wait_rsp();
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_rsp_write", 32'(r_write), 32'd0);
    chk("rd_rsp_rdata", r_rdata, 32'h0000_1234);
    chk("rd_rsp_resp", 32'(r_resp), 32'd0);
    consume();

    // random stalls, partial strobe merge
    set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    issue(1'b1, 18'h10004, 32'hA5A5_5A5A, 4'hF);
    wait_rsp(); consume();
    set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    issue(1'b1, 18'h10004, 32'h1111_2222, 4'b0101);
    wait_rsp();
    chk("strb_wr_resp", 32'(r_resp), 32'd0);
    consume();
    set_dly(0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3));
    issue(1'b0, 18'h10004, 32'h0, 4'h0);
    wait_rsp();
    chk("strb_rd_rdata", r_rdata, 32'hA511_5A22);
    consume();

    // 3: invalid addresses return SLVERR
    set_dly(0, 0, 0, 0, 0);
    issue(1'b0, 18'h00000, 32'h0, 4'h0);
    wait_rsp();
    chk("bad_rd_resp", 32'(r_resp), 32'd2);
    chk("bad_rd_rdata", r_rdata, 32'd0);
    consume();
    issue(1'b1, 18'h3F000, 32'hDEAD_BEEF, 4'hF);
    wait_rsp();
    chk("bad_wr_resp", 32'(r_resp), 32'd2);
    chk("bad_wr_rsp_write", 32'(r_write), 32'd1);
    consume();

    // 4: awready stalled, wready immediate
    set_dly(4, 0, 0, 0, 0);
    aw0 = aw_vcyc; w0 = w_vcyc; b0 = b_hs_n;
    issue(1'b1, 18'h10008, 32'h0BAD_F00D, 4'hF);
    wait_rsp();
    chk("skew_aw_cycles", 32'(aw_vcyc - aw0), 32'd5);
    chk("skew_w_cycles", 32'(w_vcyc - w0), 32'd1);
    chk("skew_b_hs", 32'(b_hs_n - b0), 32'd1);
    chk("skew_resp", 32'(r_resp), 32'd0);
    consume();

    // 5: response back-pressure
    set_dly(0, 0, 0, 0, 0);
    issue(1'b0, 18'h10008, 32'h0, 4'h0);
    wait_rsp();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_write !== r_write || rsp_resp !== r_resp ||
          rsp_rdata !== r_rdata || cmd_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_rdata", rsp_rdata, 32'h0BAD_F00D);
    consume();

    // reset while waiting in RDATA
    set_dly(0, 0, 0, 0, 20);
    issue(1'b0, 18'h10000, 32'h0, 4'h0);
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    chk("rdata_reached", 32'(rready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(cmd_ready), 32'd1);
    set_dly(0, 0, 0, 0, 0);
    issue(1'b0, 18'h10000, 32'h0, 4'h0);
    wait_rsp();
    chk("post_rst_rdata", r_rdata, 32'h0000_1234);
    consume();

    chk("axi_stability", 32'(viol), 32'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
    // 6: slave never accepts the read address
    ar_en = 1'b0;
    ar0 = ar_vcyc;
    issue(1'b0, 18'h10000, 32'h0, 4'h0);
    wait_rsp();
    chk("to_ar_cycles", 32'(ar_vcyc - ar0), 32'(TbTimeout));
    chk("to_resp", 32'(r_resp), 32'd3);
    chk("to_rdata", r_rdata, 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_arvalid", 32'(arvalid), 32'd0);
    consume();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || timeout_err !== 1'b1) stable = 1'b0;
    end
    chk("to_hung", 32'(stable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ar_en = 1'b1;
    @(negedge clk);
    chk("to_err_cleared", 32'(timeout_err), 32'd0);
`else
    ar0 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
